stream_insert_header: RTL and testbench
=======================================

Name: stream_insert_header

Overview:
Upstream companion of stream_remove_header. It prepends a per-packet header of 1..DATA_BYTE_WD bytes to a valid/ready byte stream with keep/last qualifiers, and re-packs the payload so that output beats are byte-dense. The header arrives on a separate valid/ready side channel, one header per packet. Output is registered, and the block runs at full throughput when there is no backpressure.

Parameters:
- DATA_WD, 32, data bus width in bits (multiple of 8).
- DATA_BYTE_WD, DATA_WD/8, byte lanes per beat.
- BYTE_CNT_WD, $clog2(DATA_BYTE_WD), width of byte_insert_cnt.

Ports:
- clk  in  1  clock.
- rstn  in  1  async active-low reset.
- valid_in  in  1  payload beat valid.
- data_in  in  DATA_WD  payload data; lane DATA_BYTE_WD-1 (MSB byte) is first in stream order.
- keep_in  in  DATA_BYTE_WD  byte enables, contiguous from MSB; all ones except on the last beat.
- last_in  in  1  last payload beat.
- ready_in  out  1  payload accept.
- valid_out  out  1  output beat valid.
- data_out  out  DATA_WD  output data.
- keep_out  out  DATA_BYTE_WD  output byte enables, contiguous from MSB.
- last_out  out  1  last output beat.
- ready_out  in  1  downstream accept.
- valid_insert  in  1  header valid.
- data_insert  in  DATA_WD  header; the N valid bytes sit in the low N lanes, right-aligned.
- byte_insert_cnt  in  BYTE_CNT_WD  header length minus one (N = cnt+1).
- ready_insert  out  1  header accept.

Behaviour:
- Interface decision: single clock clk; reset rstn is asynchronous, active-low.
- Reset values: valid_out=0, data_out=0, keep_out=0, last_out=0. State=S_HDR. ready_in and ready_insert are forced to 0 while rstn=0.
- Handshake: a transfer occurs when valid&&ready on the same edge.
  - data_out, keep_out and last_out stay stable while valid_out && !ready_out.
  - slot_free = !valid_out || ready_out.
- Let W=DATA_BYTE_WD, N=header bytes, V=valid bytes of the last input beat (1..W).
- S_HDR:
  - ready_insert=1, ready_in=0.
  - On fire_insert: resid <= low N bytes of data_insert, nres <= N, go to S_BODY.
  - A header accepted while the previous packet's final beat is still held in the output register is legal.
- S_BODY:
  - ready_insert=0, ready_in=slot_free.
  - On fire_in, output beat = {resid (N bytes), top W-N bytes of data_in}; then resid <= low N bytes of data_in.
  - Non-last beat: keep_out all ones, last_out=0.
  - last_in with V<=W-N: keep_out = top N+V ones, last_out=1, go to S_HDR.
  - last_in with V>W-N: keep_out all ones, last_out=0, nres <= V-(W-N), go to S_TAIL.
- S_TAIL:
  - ready_in=0, ready_insert=0.
  - When slot_free: emit resid left-aligned with keep = top nres ones, last_out=1, go to S_HDR.
- Output register: when a new beat is not loaded and ready_out=1, valid_out clears the next cycle.
- Latency: data_in or tail to valid_out is 1 cycle.
- Invalid output lanes are always driven 0.
- N=W: the whole header forms the first output beat, and every packet produces a tail beat.
- Single-beat packets are legal.
- Illegal keep_in patterns give undefined data but the FSM must not hang: it advances on last_in only.
- Reset mid-packet returns immediately to S_HDR with outputs cleared. The partial packet is dropped.

Optional Feature:
- Macro STREAM_INSERT_KEEP_CHECK_EN.
- When defined, add output port keep_err (1 bit, reset 0). It is a sticky flag set on fire_in when:
  - keep_in != all ones on a non-last beat, or
  - keep_in is non-contiguous from MSB, or
  - keep_in is zero on a last beat.
- keep_err clears only on reset.
- When undefined, the port and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared include stream_pkg.vh holds:
  - state localparams S_HDR=2'd0, S_BODY=2'd1, S_TAIL=2'd2.
  - the lane-ordering convention.
  - a keep mask function (count to MSB-contiguous mask).
- One sub-module, stream_keep_cnt: converts MSB-contiguous keep to a byte count and flags non-contiguity. It is reused by stream_remove_header.

Test Plan:
1. W=4, cnt=1 (N=2), header 0x0000AABB; beats 0x11223344 keep 1111, then 0x55667788 keep 1100 last → out 0xAABB1122/1111/last0, then 0x33445566/1111/last1.
2. cnt=0, header 0x000000CC; single beat 0x11223344 keep 1111 last → 0xCC112233/1111/last0, then 0x44000000/1000/last1 (tail).
3. cnt=3, header 0xDEADBEEF; beat 0x01020304 keep 1000 last → 0xDEADBEEF/1111/last0, then 0x01000000/1000/last1.
4. Random ready_out (50%) with 200 back-to-back packets of random N and length → output byte stream equals header+payload per packet; no beat lost or duplicated; outputs stable under stall.
5. Header presented during S_BODY/S_TAIL → ready_insert=0 until the final beat is emitted; next header accepted the following cycle.
6. rstn pulsed low during S_BODY → outputs go to 0 asynchronously; after release the next header and packet produce correct output with no residue from the old packet.

Source files
------------

// File: rtl/stream_insert_header_pkg.sv
// Shared definitions for the stream header insert/remove blocks.
// Lane ordering: lane DATA_BYTE_WD-1 (MSB byte) is first in stream order,
// so keep masks are contiguous from the MSB lane downward.
package stream_insert_header_pkg;

  typedef enum logic [1:0] {
    S_HDR  = 2'd0,
    S_BODY = 2'd1,
    S_TAIL = 2'd2
  } state_t;

  // Widest bus the mask helper can describe; callers size-cast down to W.
  localparam int MAX_BYTES = 64;

  // Byte count -> keep mask with the top cnt lanes of a w-lane beat set.
  function automatic logic [MAX_BYTES-1:0] keep_mask(input int w, input int cnt);
    logic [MAX_BYTES-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_BYTES; i++)
      if (i < w && i >= w - cnt) m[i] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/stream_keep_cnt.sv
// MSB-contiguous keep -> byte count, plus a flag for holes in the mask.
// Shared with the header-removal block.
module stream_keep_cnt #(
  parameter int W  = 4,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  keep,
  output logic [CW-1:0] cnt,
  output logic          noncontig
);

  // run[i] is set when every lane from the MSB down to lane i is kept.
  logic [W-1:0] run;

  for (genvar g = 0; g < W; g++) begin : g_lane
    assign run[g] = &keep[W-1:g];
  end

  // Count of the contiguous run; any kept lane outside it is a hole.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < W; i++) cnt = cnt + CW'(run[i]);
  end

  assign noncontig = |(keep & ~run);

endmodule

// File: rtl/stream_insert_header.sv
// Prepends a 1..W byte header to a keep/last byte stream and re-packs the
// payload so every output beat is byte-dense. One registered output stage.
// Optional: define STREAM_INSERT_KEEP_CHECK_EN to add the sticky keep_err flag.
module stream_insert_header
  import stream_insert_header_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
`ifdef STREAM_INSERT_KEEP_CHECK_EN
  output logic                    keep_err,
`endif
  input  logic                    valid_insert,
  input  logic [DATA_WD-1:0]      data_insert,
  input  logic [BYTE_CNT_WD-1:0]  byte_insert_cnt,
  output logic                    ready_insert
);

  localparam int W  = DATA_BYTE_WD;
  localparam int NW = $clog2(W + 1);

  state_t             state, state_nxt;
  logic [DATA_WD-1:0] resid, resid_nxt;     // carried bytes, right-aligned
  logic [NW-1:0]      hdr_n, hdr_n_nxt;     // header length N of this packet
  logic [NW-1:0]      tail_n, tail_n_nxt;   // valid bytes left for the tail beat

  logic               slot_free, fire_in, fire_insert;
  logic               rdy_in_c, rdy_ins_c, load;
  logic [DATA_WD-1:0] beat_data, beat_bmask;
  logic [W-1:0]       beat_keep;
  logic               beat_last;
  logic [NW-1:0]      v_cnt, ins_n;
  logic               keep_noncontig;

  assign slot_free    = !valid_out || ready_out;
  assign ready_in     = rdy_in_c & rstn;
  assign ready_insert = rdy_ins_c & rstn;
  assign fire_in      = valid_in & ready_in;
  assign fire_insert  = valid_insert & ready_insert;
  assign ins_n        = NW'(byte_insert_cnt) + NW'(1);

  stream_keep_cnt #(.W(W), .CW(NW)) u_keep_cnt (
    .keep      (keep_in),
    .cnt       (v_cnt),
    .noncontig (keep_noncontig)
  );

  // Mask of the low n bytes; n == W yields all ones (shift past width is 0).
  function automatic logic [DATA_WD-1:0] low_bytes(input int n);
    return ~({DATA_WD{1'b1}} << (8 * n));
  endfunction

  // Invalid lanes are zeroed before they reach the output register.
  for (genvar g = 0; g < W; g++) begin : g_lane
    assign beat_bmask[8*g +: 8] = {8{beat_keep[g]}};
  end

  // Next-state, handshakes and the beat to load into the output register.
  always_comb begin : p_fsm
    int n_i, v_i;
    n_i        = int'(hdr_n);
    v_i        = int'(v_cnt);
    state_nxt  = state;
    resid_nxt  = resid;
    hdr_n_nxt  = hdr_n;
    tail_n_nxt = tail_n;
    rdy_in_c   = 1'b0;
    rdy_ins_c  = 1'b0;
    load       = 1'b0;
    beat_data  = '0;
    beat_keep  = '0;
    beat_last  = 1'b0;
    case (state)
      S_HDR: begin
        rdy_ins_c = 1'b1;
        if (fire_insert) begin
          resid_nxt = data_insert & low_bytes(int'(ins_n));
          hdr_n_nxt = ins_n;
          state_nxt = S_BODY;
        end
      end
      S_BODY: begin
        rdy_in_c = slot_free;
        if (fire_in) begin
          load      = 1'b1;
          beat_data = (resid << (8 * (W - n_i))) | (data_in >> (8 * n_i));
          resid_nxt = data_in & low_bytes(n_i);
          if (!last_in) begin
            beat_keep = '1;
          end else if (v_i + n_i <= W) begin
            // Last beat fits alongside the carried bytes.
            beat_keep = W'(keep_mask(W, n_i + v_i));
            beat_last = 1'b1;
            state_nxt = S_HDR;
          end else begin
            // Spill: the low bytes of this beat need one more output beat.
            beat_keep  = '1;
            tail_n_nxt = NW'(v_i + n_i - W);
            state_nxt  = S_TAIL;
          end
        end
      end
      S_TAIL: begin
        if (slot_free) begin
          load      = 1'b1;
          beat_data = resid << (8 * (W - n_i));
          beat_keep = W'(keep_mask(W, int'(tail_n)));
          beat_last = 1'b1;
          state_nxt = S_HDR;
        end
      end
      default: state_nxt = S_HDR;
    endcase
  end

  // State and residue registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= S_HDR;
      resid  <= '0;
      hdr_n  <= NW'(1);
      tail_n <= '0;
    end else begin
      state  <= state_nxt;
      resid  <= resid_nxt;
      hdr_n  <= hdr_n_nxt;
      tail_n <= tail_n_nxt;
    end
  end

  // Output register: load only into a free slot, drop valid once taken.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_out <= 1'b0;
      data_out  <= '0;
      keep_out  <= '0;
      last_out  <= 1'b0;
    end else if (load) begin
      valid_out <= 1'b1;
      data_out  <= beat_data & beat_bmask;
      keep_out  <= beat_keep;
      last_out  <= beat_last;
    end else if (ready_out) begin
      valid_out <= 1'b0;
    end
  end

`ifdef STREAM_INSERT_KEEP_CHECK_EN
  logic keep_bad;
  assign keep_bad = (!last_in && keep_in != '1) || keep_noncontig ||
                    (last_in && keep_in == '0);

  // Sticky malformed-keep flag; only reset clears it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                    keep_err <= 1'b0;
    else if (fire_in && keep_bad) keep_err <= 1'b1;
  end
`else
  logic unused_keep_noncontig;
  assign unused_keep_noncontig = keep_noncontig;
`endif

endmodule

// File: tb/tb_stream_insert_header.sv
// Randomized bench for stream_insert_header: packets are described as byte
// lists, the expected output is header+payload chopped into W-byte beats.
module tb_stream_insert_header;

  localparam int DW = 32;
  localparam int W  = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          valid_in = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [W-1:0]  keep_in = '0;
  logic          last_in = 1'b0;
  logic          ready_in;
  logic          valid_out;
  logic [DW-1:0] data_out;
  logic [W-1:0]  keep_out;
  logic          last_out;
  logic          ready_out = 1'b1;
  logic          valid_insert = 1'b0;
  logic [DW-1:0] data_insert = '0;
  logic [CW-1:0] byte_insert_cnt = '0;
  logic          ready_insert;
`ifdef STREAM_INSERT_KEEP_CHECK_EN
  logic          keep_err;
`endif

  always #5 clk = ~clk;

  stream_insert_header #(.DATA_WD(DW)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .valid_in        (valid_in),
    .data_in         (data_in),
    .keep_in         (keep_in),
    .last_in         (last_in),
    .ready_in        (ready_in),
    .valid_out       (valid_out),
    .data_out        (data_out),
    .keep_out        (keep_out),
    .last_out        (last_out),
    .ready_out       (ready_out),
`ifdef STREAM_INSERT_KEEP_CHECK_EN
    .keep_err        (keep_err),
`endif
    .valid_insert    (valid_insert),
    .data_insert     (data_insert),
    .byte_insert_cnt (byte_insert_cnt),
    .ready_insert    (ready_insert)
  );

  int errors = 0;
  int checks = 0;

  // Stimulus queues and expected output beats.
  logic [DW-1:0] h_data[$];
  logic [CW-1:0] h_cnt[$];
  logic [DW-1:0] p_data[$];
  logic [W-1:0]  p_keep[$];
  logic          p_last[$];
  logic [DW-1:0] e_data[$];
  logic [W-1:0]  e_keep[$];
  logic          e_last[$];
  logic [7:0]    pl[$];

  bit rand_ready = 1'b0;
  bit mon_en     = 1'b0;
  int idle_pct   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Load pl with the first nb bytes (from the MSB) of v.
  task automatic set_pl(input logic [95:0] v, input int nb);
    pl.delete();
    for (int i = 0; i < nb; i++) pl.push_back(v[95-8*i -: 8]);
  endtask

  // Queue one packet: header + pl payload; build input beats and expected beats.
  task automatic add_pkt(input logic [DW-1:0] hdr, input int cnt);
    logic [7:0]    all[$];
    logic [DW-1:0] d;
    logic [W-1:0]  k;
    int            n;
    n = cnt + 1;
    h_data.push_back(hdr);
    h_cnt.push_back(CW'(cnt));
    for (int i = n - 1; i >= 0; i--) all.push_back(hdr[8*i +: 8]);
    foreach (pl[i]) all.push_back(pl[i]);
    for (int b = 0; b < pl.size(); b += W) begin
      d = $urandom;  // garbage in unkept lanes
      k = '0;
      for (int j = 0; j < W; j++)
        if (b + j < pl.size()) begin
          d[8*(W-1-j) +: 8] = pl[b+j];
          k[W-1-j] = 1'b1;
        end
      p_data.push_back(d);
      p_keep.push_back(k);
      p_last.push_back(b + W >= pl.size());
    end
    for (int b = 0; b < all.size(); b += W) begin
      d = '0;
      k = '0;
      for (int j = 0; j < W; j++)
        if (b + j < all.size()) begin
          d[8*(W-1-j) +: 8] = all[b+j];
          k[W-1-j] = 1'b1;
        end
      e_data.push_back(d);
      e_keep.push_back(k);
      e_last.push_back(b + W >= all.size());
    end
  endtask

  task automatic drive_hdrs();
    int to;
    while (h_data.size() > 0) begin
      while ($urandom_range(99) < idle_pct) begin @(posedge clk); #1; end
      valid_insert    = 1'b1;
      data_insert     = h_data[0];
      byte_insert_cnt = h_cnt[0];
      to = 0;
      @(negedge clk);
      while (!ready_insert && to < 1000) begin to++; @(negedge clk); end
      @(posedge clk); #1;
      valid_insert = 1'b0;
      if (to >= 1000) begin fail_now("hdr_accept"); h_data.delete(); end
      else begin void'(h_data.pop_front()); void'(h_cnt.pop_front()); end
    end
  endtask

  task automatic drive_beats();
    int to;
    while (p_data.size() > 0) begin
      while ($urandom_range(99) < idle_pct) begin @(posedge clk); #1; end
      valid_in = 1'b1;
      data_in  = p_data[0];
      keep_in  = p_keep[0];
      last_in  = p_last[0];
      to = 0;
      @(negedge clk);
      while (!ready_in && to < 1000) begin to++; @(negedge clk); end
      @(posedge clk); #1;
      valid_in = 1'b0;
      if (to >= 1000) begin fail_now("beat_accept"); p_data.delete(); end
      else begin void'(p_data.pop_front()); void'(p_keep.pop_front()); void'(p_last.pop_front()); end
    end
  endtask

  task automatic run_traffic();
    int to;
    fork
      drive_hdrs();
      drive_beats();
    join
    to = 0;
    while (e_data.size() > 0 && to < 2000) begin to++; @(posedge clk); #1; end
    check("drain_left", e_data.size(), 0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  // Downstream backpressure.
  initial forever begin
    @(posedge clk); #1;
    ready_out = rand_ready ? 1'($urandom_range(1)) : 1'b1;
  end

  // Compare process: new beats against the model, stalls held stable,
  // ready_insert open exactly when every accepted header's last beat is out.
  logic          pv, pr, plst;
  logic [DW-1:0] pd;
  logic [W-1:0]  pk;
  int            hcnt, lcnt;
  initial forever begin
    @(negedge clk);
    if (!rstn || !mon_en) begin
      pv = 1'b0; pr = 1'b0; hcnt = 0; lcnt = 0;
    end else begin
      if (pv && !pr) begin
        check("stall_valid", valid_out, 1'b1);
        check("stall_beat", {data_out, keep_out, last_out}, {pd, pk, plst});
      end else if (valid_out) begin
        if (e_data.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_beat: got %0h with nothing expected", data_out);
        end else begin
          check("beat_data", data_out, e_data.pop_front());
          check("beat_keep", keep_out, e_keep.pop_front());
          check("beat_last", last_out, e_last.pop_front());
        end
        if (last_out) lcnt++;
      end
      check("ready_insert", ready_insert, hcnt == lcnt);
      if (hcnt == lcnt) check("ready_in_idle", ready_in, 1'b0);
      if (valid_insert && ready_insert) hcnt++;
      pv = valid_out; pr = ready_out; pd = data_out; pk = keep_out; plst = last_out;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    #12;
    check("rst_valid_out", valid_out, 1'b0);
    check("rst_data_out", data_out, 32'h0);
    check("rst_keep_out", keep_out, 4'h0);
    check("rst_last_out", last_out, 1'b0);
    check("rst_ready_in", ready_in, 1'b0);
    check("rst_ready_insert", ready_insert, 1'b0);
    @(posedge clk); #1;
    rstn   = 1'b1;
    mon_en = 1'b1;

    // Directed packets, with the model pinned to hand-computed beats.
    set_pl(96'h112233445566_000000000000, 6);
    add_pkt(32'h0000AABB, 1);
    set_pl(96'h11223344_0000000000000000, 4);
    add_pkt(32'h000000CC, 0);
    set_pl(96'h01_0000000000000000000000, 1);
    add_pkt(32'hDEADBEEF, 3);
    check("model_in1_keep", p_keep[1], 4'b1100);
    check("model_t1_b0", {e_data[0], e_keep[0], e_last[0]}, {32'hAABB1122, 4'hF, 1'b0});
    check("model_t1_b1", {e_data[1], e_keep[1], e_last[1]}, {32'h33445566, 4'hF, 1'b1});
    check("model_t2_b0", {e_data[2], e_keep[2], e_last[2]}, {32'hCC112233, 4'hF, 1'b0});
    check("model_t2_b1", {e_data[3], e_keep[3], e_last[3]}, {32'h44000000, 4'h8, 1'b1});
    check("model_t3_b0", {e_data[4], e_keep[4], e_last[4]}, {32'hDEADBEEF, 4'hF, 1'b0});
    check("model_t3_b1", {e_data[5], e_keep[5], e_last[5]}, {32'h01000000, 4'h8, 1'b1});
    run_traffic();

    // 200 random packets under 50% backpressure and random input gaps.
    rand_ready = 1'b1;
    idle_pct   = 20;
    for (int p = 0; p < 200; p++) begin
      int len;
      len = $urandom_range(12, 1);
      pl.delete();
      for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
      add_pkt($urandom, $urandom_range(W - 1));
    end
    run_traffic();

    // Full-rate burst without gaps or backpressure.
    rand_ready = 1'b0;
    idle_pct   = 0;
    for (int p = 0; p < 20; p++) begin
      int len;
      len = $urandom_range(12, 1);
      pl.delete();
      for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
      add_pkt($urandom, $urandom_range(W - 1));
    end
    run_traffic();

    // Reset in the middle of a packet.
    mon_en = 1'b0;
    @(posedge clk); #1;
    valid_insert = 1'b1; data_insert = 32'h12345678; byte_insert_cnt = 2'd1;
    @(posedge clk); #1;
    valid_insert = 1'b0;
    valid_in = 1'b1; data_in = 32'hA1A2A3A4; keep_in = 4'hF; last_in = 1'b0;
    @(posedge clk); #1;
    valid_in = 1'b0;
    check("pre_rst_valid", valid_out, 1'b1);
    check("pre_rst_data", data_out, 32'h5678A1A2);
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_valid_out", valid_out, 1'b0);
    check("mid_rst_data_out", data_out, 32'h0);
    check("mid_rst_keep_out", keep_out, 4'h0);
    check("mid_rst_ready_in", ready_in, 1'b0);
    check("mid_rst_ready_insert", ready_insert, 1'b0);
    @(posedge clk); #1;
    rstn   = 1'b1;
    mon_en = 1'b1;
    set_pl(96'hC1C2C3C4C5_00000000000000, 5);
    add_pkt(32'h000000F0, 0);
    check("model_rst_b0", {e_data[0], e_keep[0], e_last[0]}, {32'hF0C1C2C3, 4'hF, 1'b0});
    check("model_rst_b1", {e_data[1], e_keep[1], e_last[1]}, {32'hC4C50000, 4'hC, 1'b1});
    run_traffic();
`ifdef STREAM_INSERT_KEEP_CHECK_EN
    check("keep_err_clean", keep_err, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
